// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared display geometry, word/address widths and fill-engine states
// Purpose: constants and types shared by the frame buffer arbiter and its helpers.
// Ports: none (package).
package vga_pkg;

    localparam int hDisplay      = 640;
    localparam int vDisplay      = 480;
    localparam int hWordsDefault = hDisplay / 2;   // two 8-bit pixels per 16-bit word
    localparam int wordWidth     = 16;
    localparam int addrWidth     = 18;             // {row[8:0], wordCol[8:0]}
    localparam int rowWidth      = 9;
    localparam int colWidth      = 9;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fillState_t;

endpackage

// File: rtl/frame_buffer_arbiter_shift_delay.sv
// rtl/frame_buffer_arbiter_shift_delay.sv - parameterised register chain (ShiftDelay)
// Purpose: delays a bus by a fixed number of clkDiv cycles.
// Ports: clkDiv (clock), rst (async active-low), dataIn (bus in), dataOut (bus delayed by depth cycles).
module ShiftDelay #(
    parameter int width = 1,
    parameter int depth = 3
) (
    input  logic             clkDiv,
    input  logic             rst,
    input  logic [width-1:0] dataIn,
    output logic [width-1:0] dataOut
);

    logic [width-1:0] stages [depth];

    always_ff @(posedge clkDiv or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < depth; i++) stages[i] <= '0;
        end else begin
            stages[0] <= dataIn;
            for (int i = 1; i < depth; i++) stages[i] <= stages[i-1];
        end
    end

    assign dataOut = stages[depth-1];

endmodule

// File: rtl/frame_buffer_arbiter.sv
// rtl/frame_buffer_arbiter.sv - single-port SRAM arbiter for video reads, fill engine and writer
// Purpose: every clkDiv cycle picks one memory slot (video read > fill write > writer write > idle)
//          and drives it registered on the SRAM port; returns video pixels with 3-cycle latency.
// Ports: clkDiv/rst clock and async active-low reset; row/column/displayActive timing inputs;
//        wrReq/wrAddr/wrData/wrBe/wrAck writer handshake; clrReq/clrColor/clrBusy fill control;
//        memAddr/memWe/memBe/memWdata registered SRAM command, memRdata SRAM read data;
//        pixel/pixelActive video output.
module frame_buffer_arbiter
    import vga_pkg::*;
#(
    parameter int hWords = hWordsDefault,
    parameter int vLines = vDisplay
) (
    input  logic        clkDiv,
    input  logic        rst,
    input  logic [8:0]  row,
    input  logic [9:0]  column,
    input  logic        displayActive,
    input  logic        wrReq,
    input  logic [17:0] wrAddr,
    input  logic [15:0] wrData,
    input  logic [1:0]  wrBe,
    output logic        wrAck,
    input  logic        clrReq,
    input  logic [7:0]  clrColor,
    output logic        clrBusy,
    output logic [17:0] memAddr,
    output logic        memWe,
    output logic [1:0]  memBe,
    output logic [15:0] memWdata,
    input  logic [15:0] memRdata,
    output logic [7:0]  pixel,
    output logic        pixelActive
);

    localparam logic [colWidth-1:0] lastCol = colWidth'(hWords - 1);
    localparam logic [rowWidth-1:0] lastRow = rowWidth'(vLines - 1);

    fillState_t                state, stateNext;
    logic [rowWidth-1:0]       fRow, fRowNext;
    logic [colWidth-1:0]       fCol, fColNext;
    logic [7:0]                fillColor, fillColorNext;
    logic [addrWidth-1:0]      addrNext;
    logic                      weNext, ackNext;
    logic [1:0]                beNext;
    logic [wordWidth-1:0]      wdataNext;
    logic                      videoSlot;

    // Read pipeline: rdCmd marks a read on the port, rdData marks memRdata valid,
    // hiPending marks that the saved odd pixel goes out next.
    logic                      rdCmd, rdData, hiPending;
    logic [7:0]                pixReg, hiByte;

    assign clrBusy = (state == FILL);

    always_comb begin
        stateNext     = state;
        fRowNext      = fRow;
        fColNext      = fCol;
        fillColorNext = fillColor;
        addrNext      = memAddr;
        weNext        = 1'b0;
        beNext        = memBe;
        wdataNext     = memWdata;
        ackNext       = 1'b0;
        videoSlot     = displayActive & ~column[0];

        if (state == IDLE && clrReq) begin
            stateNext     = FILL;
            fRowNext      = '0;
            fColNext      = '0;
            fillColorNext = clrColor;
        end

        if (videoSlot) begin
            addrNext = {row, column[9:1]};
            beNext   = 2'b11;
        end else if (state == FILL) begin
            addrNext  = {fRow, fCol};
            beNext    = 2'b11;
            wdataNext = {fillColor, fillColor};
            weNext    = 1'b1;
            if (fCol == lastCol) begin
                fColNext = '0;
                // Dropping to IDLE here makes clrBusy fall with the last write on the port.
                if (fRow == lastRow) stateNext = IDLE;
                else                 fRowNext  = fRow + 1'b1;
            end else begin
                fColNext = fCol + 1'b1;
            end
        end else if (wrReq && !wrAck) begin
            // wrAck high means the held request was just served; skip a cycle so the
            // writer can present its next word.
            addrNext  = wrAddr;
            beNext    = wrBe;
            wdataNext = wrData;
            weNext    = 1'b1;
            ackNext   = 1'b1;
        end
    end

    always_ff @(posedge clkDiv or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fRow      <= '0;
            fCol      <= '0;
            fillColor <= '0;
            memAddr   <= '0;
            memWe     <= 1'b0;
            memBe     <= '0;
            memWdata  <= '0;
            wrAck     <= 1'b0;
        end else begin
            state     <= stateNext;
            fRow      <= fRowNext;
            fCol      <= fColNext;
            fillColor <= fillColorNext;
            memAddr   <= addrNext;
            memWe     <= weNext;
            memBe     <= beNext;
            memWdata  <= wdataNext;
            wrAck     <= ackNext;
        end
    end

    always_ff @(posedge clkDiv or negedge rst) begin
        if (!rst) begin
            rdCmd     <= 1'b0;
            rdData    <= 1'b0;
            hiPending <= 1'b0;
            pixReg    <= '0;
            hiByte    <= '0;
        end else begin
            rdCmd     <= videoSlot;
            rdData    <= rdCmd;
            hiPending <= rdData;
            if (rdData) begin
                pixReg <= memRdata[7:0];
                hiByte <= memRdata[15:8];
            end else if (hiPending) begin
                pixReg <= hiByte;
            end
        end
    end

    ShiftDelay #(.width(1), .depth(3)) activeDelay (
        .clkDiv  (clkDiv),
        .rst     (rst),
        .dataIn  (displayActive),
        .dataOut (pixelActive)
    );

    assign pixel = pixelActive ? pixReg : 8'd0;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb/tb_frame_buffer_arbiter.sv - scoreboard bench for frame_buffer_arbiter
module tb_frame_buffer_arbiter;

    localparam int hW   = 8;
    localparam int vL   = 4;
    localparam int visW = 32;

    logic        clkDiv = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  row = '0;
    logic [9:0]  column = '0;
    logic        displayActive = 1'b0;
    logic        wrReq = 1'b0;
    logic [17:0] wrAddr = '0;
    logic [15:0] wrData = '0;
    logic [1:0]  wrBe = '0;
    logic        wrAck;
    logic        clrReq = 1'b0;
    logic [7:0]  clrColor = '0;
    logic        clrBusy;
    logic [17:0] memAddr;
    logic        memWe;
    logic [1:0]  memBe;
    logic [15:0] memWdata;
    logic [15:0] memRdata;
    logic [7:0]  pixel;
    logic        pixelActive;

    always #5 clkDiv = ~clkDiv;

    frame_buffer_arbiter #(.hWords(hW), .vLines(vL)) dut (
        .clkDiv        (clkDiv),
        .rst           (rst),
        .row           (row),
        .column        (column),
        .displayActive (displayActive),
        .wrReq         (wrReq),
        .wrAddr        (wrAddr),
        .wrData        (wrData),
        .wrBe          (wrBe),
        .wrAck         (wrAck),
        .clrReq        (clrReq),
        .clrColor      (clrColor),
        .clrBusy       (clrBusy),
        .memAddr       (memAddr),
        .memWe         (memWe),
        .memBe         (memBe),
        .memWdata      (memWdata),
        .memRdata      (memRdata),
        .pixel         (pixel),
        .pixelActive   (pixelActive)
    );

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic        ack;
        logic        busy;
    } wrExp_t;

    wrExp_t      wrQ[$];
    logic [7:0]  pixQ[$];
    logic [15:0] memArr [0:262143];
    int          vectors = 0;
    int          miscompares = 0;
    logic        monEn = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string name);
        check(name, 64'({memWe, memAddr, memBe, memWdata, wrAck, clrBusy, pixel, pixelActive}), 64'(0));
    endtask

    // SRAM model: one-cycle read latency, byte-enabled writes.
    always @(posedge clkDiv) begin
        memRdata <= memArr[memAddr];
        if (memWe) begin
            if (memBe[0]) memArr[memAddr][7:0]  <= memWdata[7:0];
            if (memBe[1]) memArr[memAddr][15:8] <= memWdata[15:8];
        end
    end

    // What the slot sampled at the last edge must produce, and displayActive history.
    logic        slotVideo;
    logic [17:0] slotAddr;
    logic [2:0]  daHist;
    logic        prevWriterWrite;

    always @(posedge clkDiv or negedge rst) begin
        if (!rst) begin
            slotVideo <= 1'b0;
            slotAddr  <= '0;
            daHist    <= '0;
        end else begin
            slotVideo <= displayActive && !column[0];
            slotAddr  <= {row, column[9:1]};
            daHist    <= {daHist[1:0], displayActive};
        end
    end

    // Monitor: compares DUT outputs against the scoreboard queues.
    always @(negedge clkDiv) begin
        if (rst && monEn) begin
            check("pixelActive", 64'(pixelActive), 64'(daHist[2]));
            if (pixelActive) begin
                if (pixQ.size() == 0) check("pixelUnderflow", 64'(1), 64'(0));
                else                  check("pixel", 64'(pixel), 64'(pixQ.pop_front()));
            end else begin
                check("pixelBlank", 64'(pixel), 64'(0));
            end
            if (slotVideo)
                check("videoRead", 64'({memWe, memBe, memAddr}), 64'({1'b0, 2'b11, slotAddr}));
            if (memWe) begin
                if (wrQ.size() == 0) begin
                    check("unexpectedWrite", 64'(memAddr), 64'(18'h3ffff) ^ 64'(memAddr) ^ 64'(1));
                end else begin
                    wrExp_t e;
                    e = wrQ.pop_front();
                    check("writeCmd", 64'({memAddr, memWdata, memBe}), 64'({e.addr, e.data, e.be}));
                    check("writeAck", 64'(wrAck), 64'(e.ack));
                    check("busyAtWrite", 64'(clrBusy), 64'(e.busy));
                    if (e.ack) check("backToBackWriter", 64'(prevWriterWrite), 64'(0));
                end
            end else begin
                check("strayAck", 64'(wrAck), 64'(0));
            end
            prevWriterWrite <= memWe && wrAck;
        end else begin
            prevWriterWrite <= 1'b0;
        end
    end

    task automatic driveLine(input logic [8:0] r, input int blank);
        logic [17:0] a;
        logic [15:0] w;
        for (int c = 0; c < visW; c++) begin
            @(negedge clkDiv);
            row = r;
            column = 10'(c);
            displayActive = 1'b1;
            a = {r, 9'(c / 2)};
            w = memArr[a];
            pixQ.push_back((c % 2 == 1) ? w[15:8] : w[7:0]);
        end
        for (int b = 0; b < blank; b++) begin
            @(negedge clkDiv);
            displayActive = 1'b0;
            column = 10'(visW + b);
        end
    endtask

    // Leaves wrReq high on return so back-to-back calls exercise the held-request guard.
    task automatic writerReq(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
        wrExp_t e;
        int n;
        @(negedge clkDiv);
        wrReq = 1'b1; wrAddr = a; wrData = d; wrBe = be;
        e.addr = a; e.data = d; e.be = be; e.ack = 1'b1; e.busy = 1'b0;
        wrQ.push_back(e);
        n = 0;
        do begin
            @(negedge clkDiv);
            n++;
        end while (!wrAck && n < 4000);
        if (!wrAck) check("wrAckTimeout", 64'(wrAck), 64'(1));
    endtask

    task automatic startFill(input logic [7:0] color);
        wrExp_t e;
        @(negedge clkDiv);
        clrReq = 1'b1;
        clrColor = color;
        for (int r = 0; r < vL; r++)
            for (int c = 0; c < hW; c++) begin
                e.addr = {9'(r), 9'(c)};
                e.data = {color, color};
                e.be   = 2'b11;
                e.ack  = 1'b0;
                e.busy = !(r == vL - 1 && c == hW - 1);
                wrQ.push_back(e);
            end
        @(negedge clkDiv);
        clrReq = 1'b0;
        clrColor = 8'($urandom);
    endtask

    task automatic waitFillDone();
        int n = 0;
        while (clrBusy && n < 5000) begin
            @(negedge clkDiv);
            n++;
        end
        check("fillTimeout", 64'(clrBusy), 64'(0));
    endtask

    task automatic randWrAddr(output logic [17:0] a);
        a = {9'($urandom_range(0, 15)), 9'($urandom_range(0, 511))};
    endtask

    logic [17:0] ra;
    logic [7:0]  col1;

    initial begin
        for (int i = 0; i < 262144; i++) memArr[i] = '0;
        for (int r = 16; r < 480; r++)
            for (int k = 0; k < visW / 2; k++)
                memArr[{9'(r), 9'(k)}] = 16'($urandom);
        memArr[{9'd20, 9'd0}] = 16'hBBAA;

        #1 rst = 1'b0;
        repeat (3) @(negedge clkDiv);
        checkAllZero("resetState");
        #2 rst = 1'b1;
        repeat (2) @(negedge clkDiv);
        monEn = 1'b1;

        // Plain video lines with random porches.
        driveLine(9'd20, 5);
        for (int i = 0; i < 3; i++) driveLine(9'($urandom_range(16, 479)), $urandom_range(2, 10));

        // Writer held across a visible line.
        fork
            driveLine(9'($urandom_range(16, 479)), 12);
            begin
                writerReq(18'h00005, 16'h1234, 2'b01);
                for (int i = 0; i < 5; i++) begin
                    randWrAddr(ra);
                    writerReq(ra, 16'($urandom), 2'($urandom));
                end
                wrReq = 1'b0;
            end
        join

        // Fills during blanking.
        startFill(8'h3C);
        waitFillDone();
        startFill(8'($urandom));
        waitFillDone();

        // Fill against video, writer waiting on the fill, second clrReq ignored.
        col1 = 8'($urandom);
        fork
            begin
                startFill(col1);
                repeat (6) @(negedge clkDiv);
                clrReq = 1'b1;
                clrColor = ~col1;
                @(negedge clkDiv);
                clrReq = 1'b0;
            end
            begin
                driveLine(9'($urandom_range(16, 479)), 4);
                driveLine(9'($urandom_range(16, 479)), 40);
            end
            begin
                repeat (3) @(negedge clkDiv);
                randWrAddr(ra);
                writerReq(ra, 16'($urandom), 2'b11);
                wrReq = 1'b0;
            end
        join
        waitFillDone();
        repeat (4) @(negedge clkDiv);

        // Reset mid-fill.
        startFill(8'($urandom));
        repeat (10) @(negedge clkDiv);
        #2 rst = 1'b0;
        #1 checkAllZero("resetMidFill");
        wrQ.delete();
        repeat (2) @(negedge clkDiv);
        #2 rst = 1'b1;
        repeat (20) @(negedge clkDiv);
        check("busyAfterReset", 64'(clrBusy), 64'(0));

        // Reset while the write ack is on the port.
        randWrAddr(ra);
        writerReq(ra, 16'($urandom), 2'b10);
        #2 rst = 1'b0;
        wrReq = 1'b0;
        #1 checkAllZero("resetMidWrite");
        wrQ.delete();
        repeat (2) @(negedge clkDiv);
        #2 rst = 1'b1;
        repeat (20) @(negedge clkDiv);

        driveLine(9'($urandom_range(16, 479)), 6);
        repeat (4) @(negedge clkDiv);
        check("writeQueueDrained", 64'(wrQ.size()), 64'(0));
        check("pixelQueueDrained", 64'(pixQ.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
